// File: rtl/cluster_load_sequencer_pkg.sv
// Shared types and sizing for the cluster load sequencer and its load engine.
// The optional overlapped-load build is selected with CLUSTER_LOAD_OVERLAP_EN;
// it adds the WAIT_LOAD state to the state enum.
package cluster_load_sequencer_pkg;

  localparam int WR_DAT_CYC_NUM   = 4;
  localparam int COMPUTE_UNIT_NUM = 4;
  localparam int SRAM_IFM_NUM     = 8;
  localparam int SRAM_FILTER_NUM  = 16;
  localparam int CHUNK_NUM_W      = 8;

  localparam int BEAT_W    = $clog2(WR_DAT_CYC_NUM);
  localparam int CU_W      = $clog2(COMPUTE_UNIT_NUM);
  localparam int IFM_IDX_W = $clog2(SRAM_IFM_NUM);
  localparam int FLT_IDX_W = $clog2(SRAM_FILTER_NUM);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
`ifdef CLUSTER_LOAD_OVERLAP_EN
    ST_WAIT_LOAD = 3'd3,
`endif
    ST_DONE      = 3'd4
  } seq_state_e;

  // A chunk load streams every CU's filter chunk first, then the IFM chunk.
  typedef enum logic {
    PH_FILTER = 1'b0,
    PH_IFM    = 1'b1
  } load_phase_e;

  function automatic logic [COMPUTE_UNIT_NUM-1:0] cu_onehot(input logic [CU_W-1:0] cu);
    logic [COMPUTE_UNIT_NUM-1:0] sel;
    sel     = '0;
    sel[cu] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/cluster_load_sequencer_if.sv
// Sequencer <-> compute-cluster wrapper signal bundle.
// master: the sequencer; slave: the cluster/memory wrapper.
interface cluster_load_sequencer_if;
  import cluster_load_sequencer_pkg::*;

  logic                        ifm_chunk_wr_valid_o;
  logic [BEAT_W-1:0]           ifm_chunk_wr_count_o;
  logic [IFM_IDX_W-1:0]        ifm_sram_rd_count_o;
  logic                        filter_chunk_wr_valid_o;
  logic [BEAT_W-1:0]           filter_chunk_wr_count_o;
  logic [COMPUTE_UNIT_NUM-1:0] filter_chunk_cu_wr_sel_o;
  logic [FLT_IDX_W-1:0]        filter_sram_rd_count_o;
  logic                        chunk_wr_sel_o;
  logic                        chunk_rd_sel_o;
  logic                        run_valid_o;
  logic                        total_chunk_start_o;
  logic                        total_chunk_end_i;

  modport master (
    output ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o, ifm_sram_rd_count_o,
    output filter_chunk_wr_valid_o, filter_chunk_wr_count_o,
    output filter_chunk_cu_wr_sel_o, filter_sram_rd_count_o,
    output chunk_wr_sel_o, chunk_rd_sel_o, run_valid_o, total_chunk_start_o,
    input  total_chunk_end_i
  );

  modport slave (
    input  ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o, ifm_sram_rd_count_o,
    input  filter_chunk_wr_valid_o, filter_chunk_wr_count_o,
    input  filter_chunk_cu_wr_sel_o, filter_sram_rd_count_o,
    input  chunk_wr_sel_o, chunk_rd_sel_o, run_valid_o, total_chunk_start_o,
    output total_chunk_end_i
  );

endinterface

// File: rtl/cluster_chunk_load_engine.sv
// Chunk load engine: on go_i streams one chunk (every CU's filter chunk, then
// the IFM chunk) out of the zero-latency SRAMs. Owns the beat, CU and SRAM
// chunk index counters; the indices persist across chunks until clr_i.
// done_o is a level: high whenever no load will be outstanding after this
// cycle (engine idle, or on the final IFM beat).
module cluster_chunk_load_engine
  import cluster_load_sequencer_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        go_i,
  input  logic                        clr_i,
  output logic                        done_o,
  output logic                        filter_valid_o,
  output logic [BEAT_W-1:0]           filter_count_o,
  output logic [COMPUTE_UNIT_NUM-1:0] filter_cu_sel_o,
  output logic [FLT_IDX_W-1:0]        filter_idx_o,
  output logic                        ifm_valid_o,
  output logic [BEAT_W-1:0]           ifm_count_o,
  output logic [IFM_IDX_W-1:0]        ifm_idx_o
);

  localparam logic [BEAT_W-1:0]    BEAT_LAST    = BEAT_W'(WR_DAT_CYC_NUM - 1);
  localparam logic [CU_W-1:0]      CU_LAST      = CU_W'(COMPUTE_UNIT_NUM - 1);
  localparam logic [IFM_IDX_W-1:0] IFM_IDX_LAST = IFM_IDX_W'(SRAM_IFM_NUM - 1);
  localparam logic [FLT_IDX_W-1:0] FLT_IDX_LAST = FLT_IDX_W'(SRAM_FILTER_NUM - 1);

  logic                 active_q, active_d;
  load_phase_e          phase_q, phase_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [CU_W-1:0]      cu_q, cu_d;
  logic [IFM_IDX_W-1:0] ifm_idx_q, ifm_idx_d;
  logic [FLT_IDX_W-1:0] flt_idx_q, flt_idx_d;
  logic                 last_beat;

  // Register the beat/CU/index counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      active_q  <= 1'b0;
      phase_q   <= PH_FILTER;
      beat_q    <= '0;
      cu_q      <= '0;
      ifm_idx_q <= '0;
      flt_idx_q <= '0;
    end else begin
      active_q  <= active_d;
      phase_q   <= phase_d;
      beat_q    <= beat_d;
      cu_q      <= cu_d;
      ifm_idx_q <= ifm_idx_d;
      flt_idx_q <= flt_idx_d;
    end
  end

  // Advance beat -> CU -> phase; SRAM indices step at CU and chunk boundaries.
  always_comb begin
    active_d  = active_q;
    phase_d   = phase_q;
    beat_d    = beat_q;
    cu_d      = cu_q;
    ifm_idx_d = ifm_idx_q;
    flt_idx_d = flt_idx_q;
    last_beat = active_q && (beat_q == BEAT_LAST);

    if (active_q) begin
      if (last_beat) begin
        beat_d = '0;
        if (phase_q == PH_FILTER) begin
          flt_idx_d = (flt_idx_q == FLT_IDX_LAST) ? '0 : flt_idx_q + FLT_IDX_W'(1);
          if (cu_q == CU_LAST) begin
            cu_d    = '0;
            phase_d = PH_IFM;
          end else begin
            cu_d = cu_q + CU_W'(1);
          end
        end else begin
          ifm_idx_d = (ifm_idx_q == IFM_IDX_LAST) ? '0 : ifm_idx_q + IFM_IDX_W'(1);
          active_d  = 1'b0;
          phase_d   = PH_FILTER;
        end
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    if (clr_i) begin
      ifm_idx_d = '0;
      flt_idx_d = '0;
    end

    // go may land on the final beat of the previous load; it simply restarts.
    if (go_i) begin
      active_d = 1'b1;
      phase_d  = PH_FILTER;
      beat_d   = '0;
      cu_d     = '0;
    end
  end

  // Beat strobes and counts; counts and CU select read zero when not writing.
  always_comb begin
    filter_valid_o  = active_q && (phase_q == PH_FILTER);
    ifm_valid_o     = active_q && (phase_q == PH_IFM);
    filter_count_o  = filter_valid_o ? beat_q : '0;
    ifm_count_o     = ifm_valid_o ? beat_q : '0;
    filter_cu_sel_o = filter_valid_o ? cu_onehot(cu_q) : '0;
    filter_idx_o    = flt_idx_q;
    ifm_idx_o       = ifm_idx_q;
    done_o          = !active_q || (last_beat && (phase_q == PH_IFM));
  end

endmodule

// File: rtl/cluster_load_sequencer.sv
// Cluster load sequencer top: loads each chunk into the ping-pong chunk
// buffers through the load engine, then gates the cluster compute run.
// Optional build macro CLUSTER_LOAD_OVERLAP_EN: load chunk k+1 while chunk k
// computes, waiting in WAIT_LOAD if the compute finishes first.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start_i
// LOAD      | engine streaming the current chunk into bank wr_sel
// RUN       | cluster computing bank rd_sel; waiting for total_chunk_end_i
// WAIT_LOAD | (overlap build) compute ended before the next load finished
// DONE      | one-cycle completion pulse, then IDLE
module cluster_load_sequencer
  import cluster_load_sequencer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CHUNK_NUM_W-1:0] chunk_num_i,
  output logic                   busy_o,
  output logic                   done_o,
  cluster_load_sequencer_if.master cl
);

  seq_state_e             state_q, state_d;
  logic [CHUNK_NUM_W-1:0] k_q, k_d;
  logic [CHUNK_NUM_W-1:0] num_q, num_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   first_q, first_d;
  logic                   run_enter;
  logic                   eng_go;
  logic                   eng_clr;
  logic                   eng_done;

  cluster_chunk_load_engine u_load_engine (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .go_i            (eng_go),
    .clr_i           (eng_clr),
    .done_o          (eng_done),
    .filter_valid_o  (cl.filter_chunk_wr_valid_o),
    .filter_count_o  (cl.filter_chunk_wr_count_o),
    .filter_cu_sel_o (cl.filter_chunk_cu_wr_sel_o),
    .filter_idx_o    (cl.filter_sram_rd_count_o),
    .ifm_valid_o     (cl.ifm_chunk_wr_valid_o),
    .ifm_count_o     (cl.ifm_chunk_wr_count_o),
    .ifm_idx_o       (cl.ifm_sram_rd_count_o)
  );

  // State, chunk counter, bank selects and first-RUN-cycle flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      num_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      num_q    <= num_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      first_q  <= first_d;
    end
  end

  // Next-state logic, load-engine requests and bank swap at RUN entry.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    num_d     = num_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    run_enter = 1'b0;
    eng_go    = 1'b0;
    eng_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          eng_clr  = 1'b1;
          k_d      = '0;
          wr_sel_d = 1'b0;
          if (chunk_num_i == '0) begin
            state_d = ST_DONE;
          end else begin
            num_d   = chunk_num_i;
            eng_go  = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (eng_done) begin
          run_enter = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cl.total_chunk_end_i) begin
          if (k_q == num_q - CHUNK_NUM_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            k_d = k_q + CHUNK_NUM_W'(1);
`ifdef CLUSTER_LOAD_OVERLAP_EN
            if (eng_done) begin
              run_enter = 1'b1;
              state_d   = ST_RUN;
            end else begin
              state_d = ST_WAIT_LOAD;
            end
`else
            eng_go  = 1'b1;
            state_d = ST_LOAD;
`endif
          end
        end
      end
`ifdef CLUSTER_LOAD_OVERLAP_EN
      ST_WAIT_LOAD: begin
        if (eng_done) begin
          run_enter = 1'b1;
          state_d   = ST_RUN;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The freshly loaded bank becomes the compute bank.
    if (run_enter) begin
      rd_sel_d = wr_sel_q;
      wr_sel_d = ~wr_sel_q;
    end

`ifdef CLUSTER_LOAD_OVERLAP_EN
    // Prefetch the next chunk during this RUN; engine is active on its first cycle.
    if (run_enter && (({1'b0, k_d} + (CHUNK_NUM_W + 1)'(1)) < {1'b0, num_q})) begin
      eng_go = 1'b1;
    end
`endif

    first_d = run_enter;
  end

  // Job status and compute gating.
  always_comb begin
    busy_o                 = (state_q != ST_IDLE);
    done_o                 = (state_q == ST_DONE);
    cl.run_valid_o         = (state_q == ST_RUN);
    cl.total_chunk_start_o = (state_q == ST_RUN) && first_q;
    cl.chunk_wr_sel_o      = wr_sel_q;
    cl.chunk_rd_sel_o      = rd_sel_q;
  end

endmodule

// File: tb/tb_cluster_load_sequencer.sv
// Scoreboard bench for cluster_load_sequencer. Each job pushes the expected
// filter beats, IFM beats, RUN start pulses and done pulse (with cycle stamps)
// into per-kind queues; the monitor pops and compares whenever the DUT
// presents the matching strobe.
module tb_cluster_load_sequencer;
  import cluster_load_sequencer_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start_i = 1'b0;
  logic [CHUNK_NUM_W-1:0] chunk_num_i = '0;
  logic                   busy_o;
  logic                   done_o;

  cluster_load_sequencer_if cl_if();

  cluster_load_sequencer u_dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start_i),
    .chunk_num_i (chunk_num_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cl          (cl_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t fq[$];
  ev_t iq[$];
  ev_t sq[$];
  ev_t dq[$];

  int m_ifm;
  int m_flt;
  bit m_wr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int out_vec();
    return int'({cl_if.filter_chunk_wr_valid_o, cl_if.filter_chunk_wr_count_o,
                 cl_if.filter_chunk_cu_wr_sel_o, cl_if.filter_sram_rd_count_o,
                 cl_if.ifm_chunk_wr_valid_o, cl_if.ifm_chunk_wr_count_o,
                 cl_if.ifm_sram_rd_count_o, cl_if.chunk_wr_sel_o, cl_if.chunk_rd_sel_o,
                 cl_if.run_valid_o, cl_if.total_chunk_start_o});
  endfunction

  // Expected beats of one chunk load starting at cycle ls.
  task automatic push_load(input int ls);
    for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
      for (int b = 0; b < WR_DAT_CYC_NUM; b++)
        fq.push_back('{ls + c * WR_DAT_CYC_NUM + b, 1 << c, b, m_flt});
      m_flt = (m_flt + 1) % SRAM_FILTER_NUM;
    end
    for (int b = 0; b < WR_DAT_CYC_NUM; b++)
      iq.push_back('{ls + COMPUTE_UNIT_NUM * WR_DAT_CYC_NUM + b, b, m_ifm, 0});
    m_ifm = (m_ifm + 1) % SRAM_IFM_NUM;
  endtask

  // Monitor: pop and compare on every DUT strobe.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("valids_exclusive",
          int'(cl_if.filter_chunk_wr_valid_o && cl_if.ifm_chunk_wr_valid_o), 0);
      if (cl_if.filter_chunk_wr_valid_o) begin
        chk("filter_beat_expected", int'(fq.size() > 0), 1);
        if (fq.size() > 0) begin
          e = fq.pop_front();
          chk("filter_cycle", cyc, e.cyc);
          chk("filter_cu_sel", int'(cl_if.filter_chunk_cu_wr_sel_o), e.a);
          chk("filter_count", int'(cl_if.filter_chunk_wr_count_o), e.b);
          chk("filter_sram_idx", int'(cl_if.filter_sram_rd_count_o), e.c);
        end
      end else begin
        chk("filter_idle_zero",
            int'({cl_if.filter_chunk_cu_wr_sel_o, cl_if.filter_chunk_wr_count_o}), 0);
      end
      if (cl_if.ifm_chunk_wr_valid_o) begin
        chk("ifm_beat_expected", int'(iq.size() > 0), 1);
        if (iq.size() > 0) begin
          e = iq.pop_front();
          chk("ifm_cycle", cyc, e.cyc);
          chk("ifm_count", int'(cl_if.ifm_chunk_wr_count_o), e.a);
          chk("ifm_sram_idx", int'(cl_if.ifm_sram_rd_count_o), e.b);
        end
      end else begin
        chk("ifm_count_idle_zero", int'(cl_if.ifm_chunk_wr_count_o), 0);
      end
      if (cl_if.total_chunk_start_o) begin
        chk("run_start_expected", int'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          e = sq.pop_front();
          chk("run_start_cycle", cyc, e.cyc);
          chk("run_rd_sel", int'(cl_if.chunk_rd_sel_o), e.a);
          chk("run_wr_sel", int'(cl_if.chunk_wr_sel_o), e.b);
          chk("run_valid_at_start", int'(cl_if.run_valid_o), e.c);
        end
      end
      if (done_o) begin
        done_seen++;
        chk("done_expected", int'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("busy_during_done", int'(busy_o), 1);
        end
      end
    end
  end

  task automatic check_drained();
    chk("filter_q_drained", fq.size(), 0);
    chk("ifm_q_drained", iq.size(), 0);
    chk("start_q_drained", sq.size(), 0);
    chk("done_q_drained", dq.size(), 0);
  endtask

  // One job: d0/dn = cycles from RUN start to total_chunk_end_i for chunk 0 / later
  // chunks. disturb adds an ignored start (chunk_num 7) and a stray end in LOAD.
  task automatic run_job(input int num, input int d0, input int dn, input bit disturb);
    int t0, ls, rstart, te, tdone;
    int rs[16];
    int re[16];
    bit rd, busy_exp, run_exp, end_drv;
`ifdef CLUSTER_LOAD_OVERLAP_EN
    int ldone;
`endif
    t0 = cyc + 1;
    m_ifm = 0;
    m_flt = 0;
    m_wr = 1'b0;
    tdone = t0 + 1;
    for (int i = 0; i < 16; i++) begin
      rs[i] = -1;
      re[i] = -2;
    end
    if (num == 0) begin
      dq.push_back('{tdone, 0, 0, 0});
    end else begin
      ls = t0 + 1;
      push_load(ls);
      rstart = ls + 20;
      for (int k = 0; k < num; k++) begin
        te = rstart + ((k == 0) ? d0 : dn);
        rs[k] = rstart;
        re[k] = te;
        rd = m_wr;
        m_wr = ~m_wr;
        sq.push_back('{rstart, int'(rd), int'(m_wr), 1});
        if (k == num - 1) begin
          tdone = te + 1;
          dq.push_back('{tdone, 0, 0, 0});
        end else begin
`ifdef CLUSTER_LOAD_OVERLAP_EN
          ls = rstart;
          push_load(ls);
          ldone = ls + 19;
          rstart = (te >= ldone) ? te + 1 : ldone + 1;
`else
          ls = te + 1;
          push_load(ls);
          rstart = ls + 20;
`endif
        end
      end
    end
    while (cyc < tdone + 2) begin
      @(posedge clk);
      #1;
      start_i = (cyc == t0) || (disturb && cyc == t0 + 5);
      chunk_num_i = (cyc == t0) ? CHUNK_NUM_W'(num) : CHUNK_NUM_W'(7);
      end_drv = disturb && (cyc == t0 + 3);
      for (int k = 0; k < 16; k++)
        if (re[k] == cyc) end_drv = 1'b1;
      cl_if.total_chunk_end_i = end_drv;
      @(negedge clk);
      busy_exp = (cyc >= t0 + 1) && (cyc <= tdone);
      run_exp = 1'b0;
      for (int k = 0; k < 16; k++)
        if (cyc >= rs[k] && cyc <= re[k]) run_exp = 1'b1;
      chk("busy_level", int'(busy_o), int'(busy_exp));
      chk("run_valid_level", int'(cl_if.run_valid_o), int'(run_exp));
    end
    start_i = 1'b0;
    cl_if.total_chunk_end_i = 1'b0;
    check_drained();
  endtask

  // Abort a job with reset during filter beat 2 of CU 1.
  task automatic reset_abort();
    int t0, ds0;
    t0 = cyc + 1;
    ds0 = done_seen;
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < WR_DAT_CYC_NUM; b++)
        if (c * WR_DAT_CYC_NUM + b <= 6)
          fq.push_back('{t0 + 1 + c * WR_DAT_CYC_NUM + b, 1 << c, b, c});
    while (cyc < t0 + 7) begin
      @(posedge clk);
      #1;
      start_i = (cyc == t0);
      chunk_num_i = CHUNK_NUM_W'(4);
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("abort_in_filter_phase", int'(cl_if.filter_chunk_cu_wr_sel_o), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", out_vec(), 0);
    chk("abort_busy_low", int'(busy_o), 0);
    chk("abort_done_low", int'(done_o), 0);
    repeat (2) @(negedge clk);
    chk("abort_held_zero", out_vec(), 0);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_after_release", out_vec(), 0);
    chk("abort_no_done_pulse", done_seen, ds0);
    check_drained();
  endtask

  initial begin
    cl_if.total_chunk_end_i = 1'b0;
    #3;
    chk("reset_outputs_zero", out_vec(), 0);
    chk("reset_busy_low", int'(busy_o), 0);
    chk("reset_done_low", int'(done_o), 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(1, 5, 5, 1'b0);
    run_job(3, 3, 3, 1'b0);
    run_job(10, 2, 2, 1'b0);
    run_job(2, 1, 1, 1'b0);
    run_job(2, 30, 30, 1'b0);
    run_job(0, 0, 0, 1'b0);
    run_job(2, 3, 3, 1'b1);
    reset_abort();
    run_job(1, 0, 0, 1'b0);
    run_job(3, 0, 25, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cluster_load_sequencer.md
Name: cluster_load_sequencer

Overview:
- Control stage directly upstream of the compute-cluster/memory wrapper. Sequences IFM and filter SRAM chunk reads into the cluster's ping-pong chunk buffers, then gates the compute run for each chunk.
- Drives the cluster's chunk write/read selects, per-CU filter write select, SRAM read chunk indices, run_valid and total_chunk_start. Consumes total_chunk_end.
- SRAM read is zero-latency: the data count and its valid are driven in the same cycle.

Parameters:
WR_DAT_CYC_NUM, 4, bus beats per chunk.
COMPUTE_UNIT_NUM, 4, compute units; one filter chunk is loaded per CU per chunk.
SRAM_IFM_NUM, 8, IFM SRAM chunk slots.
SRAM_FILTER_NUM, 16, filter SRAM chunk slots.
CHUNK_NUM_W, 8, width of the job chunk count.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
start_i  in  1  job start pulse; honoured only in IDLE
chunk_num_i  in  CHUNK_NUM_W  number of chunks in the job, sampled on start_i
busy_o  out  1  high from the cycle after an accepted start until DONE exits
done_o  out  1  one-cycle job completion pulse
ifm_chunk_wr_valid_o  out  1  IFM chunk buffer write strobe
ifm_chunk_wr_count_o  out  clog2(WR_DAT_CYC_NUM)  IFM beat index; also the SRAM read beat
ifm_sram_rd_count_o  out  clog2(SRAM_IFM_NUM)  IFM SRAM chunk index
filter_chunk_wr_valid_o  out  1  filter chunk buffer write strobe
filter_chunk_wr_count_o  out  clog2(WR_DAT_CYC_NUM)  filter beat index
filter_chunk_cu_wr_sel_o  out  COMPUTE_UNIT_NUM  one-hot target CU; zero when idle
filter_sram_rd_count_o  out  clog2(SRAM_FILTER_NUM)  filter SRAM chunk index
chunk_wr_sel_o  out  1  buffer bank being written (drives both the IFM and filter wr_sel)
chunk_rd_sel_o  out  1  buffer bank being computed (drives both rd_sel)
run_valid_o  out  1  compute enable
total_chunk_start_o  out  1  pulse on the first RUN cycle of every chunk
total_chunk_end_i  in  1  cluster pulse marking the end of the current chunk's compute

Behaviour:
- Reset: all outputs 0, both selects 0, state IDLE. Reset asserted mid-operation aborts immediately with no completion pulse.
- IDLE:
  - start_i with chunk_num_i=0: done_o pulses next cycle; no valids are issued.
  - start_i with chunk_num_i!=0: capture chunk_num_i; k=0, ifm index=0, filter index=0, wr_sel=0; go to LOAD.
  - start_i in any other state is ignored.
- LOAD (load engine), COMPUTE_UNIT_NUM*WR_DAT_CYC_NUM + WR_DAT_CYC_NUM cycles:
  - Filter subphase: for cu=0..CU-1, WR_DAT_CYC_NUM beats with filter_chunk_wr_valid=1, cu_wr_sel=1<<cu, count 0..W-1. filter_sram_rd_count increments after each CU, wrapping mod SRAM_FILTER_NUM.
  - IFM subphase: W beats with ifm_chunk_wr_valid=1, count 0..W-1. ifm_sram_rd_count increments once at chunk end, wrapping mod SRAM_IFM_NUM.
  - Counts return to 0 when valids are low. The two valids are never high together.
- LOAD done: rd_sel<=wr_sel, wr_sel toggles, go to RUN.
- RUN: run_valid=1; total_chunk_start_o on the first cycle only.
  - total_chunk_end_i: if k=chunk_num-1, go to DONE; else k++ and go to LOAD.
  - total_chunk_end_i is ignored outside RUN.
  - total_chunk_end_i in the same cycle as the start pulse is accepted (single-cycle run).
- DONE: done_o=1 for one cycle, busy_o falls, return to IDLE.
- Index counters persist across chunks within a job and are cleared on start.

Optional Feature:
- CLUSTER_LOAD_OVERLAP_EN defined:
  - Loading chunk k+1 into bank wr_sel starts on the first RUN cycle of chunk k (when k+1 < chunk_num).
  - On total_chunk_end_i: if the load is complete, the next cycle is RUN with swapped selects. Otherwise go to WAIT_LOAD (run_valid=0) until it completes, then RUN.
  - Selects swap only at RUN entry.
- Undefined: strictly serial LOAD then RUN, as above; WAIT_LOAD does not exist.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, WAIT_LOAD, DONE), beat/CU/index width localparams, and the one-hot CU select function.
- Sub-module cluster_chunk_load_engine: go/done handshake; owns the beat, CU and SRAM index counters. The top FSM owns k, the selects and the run gating.

Test Plan:
- Defaults, chunk_num=1, start at cycle 0, no overlap -> cu_wr_sel sequence 0001,0010,0100,1000, each for 4 beats with counts 0..3; 4 IFM beats; run_valid and start pulse at cycle 21; end_i 5 cycles later -> done_o one cycle, busy_o low.
- chunk_num=3 -> ifm_sram_rd_count 0,1,2; filter_sram_rd_count 0..11; rd_sel per RUN 0,1,0; three start pulses.
- chunk_num=10 -> ifm index wraps 7->0; filter index wraps 15->0 at the fourth chunk.
- Overlap, chunk_num=2, end_i 2 cycles into the first RUN -> WAIT_LOAD with run_valid=0 for 18 cycles, then RUN with rd_sel=1. Repeat with end_i after 30 cycles -> RUN immediately, no gap.
- Reset low during the filter subphase at beat 2 of CU 1 -> all outputs 0 asynchronously, no done_o. A new start after release begins at indices 0.
- start_i with chunk_num=0 -> done_o next cycle, zero valids. start_i pulsed while busy -> ignored, with no change to k or the indices.
